mcbsp_tdm_master: RTL and testbench
===================================

Name: mcbsp_tdm_master

Overview:
- Single-clock, parametrised McBSP-style serial master. Generates the bit clock `sclk` internally from `clk`.
- Frames are multi-slot TDM: one frame sync `fs` per frame, then SLOTS words of WIDTH bits each.
- Full duplex: transmits on `dx` and receives on `dr` in the same frame.
- Sits between the FPGA datapath (valid/ready words) and the DSP serial port. Replaces the fixed 32-bit, dual-clock transmitter/receiver pair.

Parameters:
WIDTH, 32, bits per slot word, 8..32
SLOTS, 2, words per frame, 1..16
CLK_DIV, 4, half-period of sclk in clk cycles, >=1 (bit period = 2*CLK_DIV clk)
DATA_DELAY, 1, bit periods between the start of fs and the first data bit, 0..2
LSB_FIRST, 0, 0 = MSB first, 1 = LSB first

Ports:
clk  in  1  system clock; all logic on its rising edge
rst_n  in  1  synchronous reset, active-low
en  in  1  frame enable; sampled at frame boundaries
tx_data  in  WIDTH  word to transmit
tx_valid  in  1  tx_data valid
tx_ready  out  1  holding register empty; transfer occurs when tx_valid && tx_ready
rx_data  out  WIDTH  last received word
rx_slot  out  4  slot index of rx_data, 0..SLOTS-1
rx_valid  out  1  one-clk pulse; rx_data and rx_slot are valid
tx_underrun  out  1  one-clk pulse; a slot started with an empty holding register
frame_done  out  1  one-clk pulse after the last data bit of a frame
busy  out  1  high while a frame is in progress
sclk  out  1  serial bit clock
fs  out  1  frame sync, active high
dx  out  1  serial data to DSP
dr  in  1  serial data from DSP

Behaviour:
Reset (rst_n=0 at a clk edge):
- All outputs 0, including sclk, fs, dx, tx_ready; divider, counters and registers cleared; state IDLE.
- tx_ready rises on the first clk after release.
- Reset mid-frame aborts immediately: the partial rx word is discarded and no rx_valid, frame_done or tx_underrun is issued.

Bit clock:
- Divider counts 0..CLK_DIV-1 and toggles sclk at the terminal count; it runs free from reset release.
- F-event = clk cycle in which sclk goes 1->0; R-event = clk cycle in which sclk goes 0->1.
- dx and fs change only on F-events. dr is sampled only on R-events (the first R-event after a bit is driven).

State machine IDLE -> SYNC -> DATA -> IDLE/SYNC:
- IDLE:
  - fs=0, dx=0, busy=0.
  - On an F-event with en=1: go to SYNC, busy=1, fs=1 for exactly one bit period.
- SYNC:
  - Lasts DATA_DELAY bit periods; dx=0 during it.
  - DATA_DELAY=0: SYNC is skipped and fs is coincident with data bit 0 of slot 0.
- DATA:
  - SLOTS*WIDTH bit periods; slot counter 0..SLOTS-1, bit counter 0..WIDTH-1.
  - Bit order follows LSB_FIRST.
- End of frame, at the F-event after the last data bit:
  - frame_done pulses.
  - en=1: the next frame starts at that same F-event (back-to-back; fs high again).
  - en=0: return to IDLE.
- en deasserted mid-frame never truncates the frame.

TX holding register (1 deep):
- tx_valid && tx_ready loads it; tx_ready drops on the next clk.
- At the F-event that drives bit 0 of a slot:
  - If holding is full: move it to the shift register; tx_ready=1 on the next clk.
  - If holding is empty: shift zeros for that slot and pulse tx_underrun.
- The holding state is taken before that cycle's handshake. A word accepted in the load cycle stays in holding for the next slot.
- A word accepted in IDLE is kept until the first slot of the next frame.

RX:
- Bits shift in on R-events.
- On the R-event of a slot's last bit: rx_data and rx_slot are registered and rx_valid pulses on the next clk.
- No backpressure: rx_data is overwritten each slot.

Latency:
- Frame length = DATA_DELAY + SLOTS*WIDTH bit periods.
- rx_valid for slot k occurs 1 clk after the R-event of bit (k+1)*WIDTH-1.

Test Plan:
- WIDTH=8, SLOTS=2, CLK_DIV=2, DATA_DELAY=1, dx looped to dr; preload 0xA5, then 0x3C; en=1 for one frame -> fs high 4 clk; rx_valid twice with (0xA5, slot 0), (0x3C, slot 1); frame_done 68 clk after fs rises; 0 underruns.
- Same config, only 0xA5 supplied -> slot 1 transmits 0x00; tx_underrun pulses once at the slot-1 start; rx slot 1 = 0x00.
- DATA_DELAY=0, LSB_FIRST=1, send 0x01 -> dx=1 during the first bit, coincident with fs=1; rx_data=0x01.
- en held high for 3 frames with continuous tx_valid -> fs every 16 bit periods, no idle bit between frames, 6 rx_valid, busy stays 1.
- en dropped during slot 0 -> frame completes with both slots received; busy falls after frame_done; no new fs.
- rst_n=0 for 1 clk mid slot 1 -> all outputs 0 the next clk; no rx_valid for the partial word; a fresh frame after release is correct.

Source files
------------

// File: rtl/mcbsp_tdm_master.sv
// McBSP-style TDM serial master: internal sclk, one fs per frame,
// SLOTS words of WIDTH bits, full duplex with a 1-deep tx holding register.
module mcbsp_tdm_master #(
    parameter int WIDTH      = 32,
    parameter int SLOTS      = 2,
    parameter int CLK_DIV    = 4,
    parameter int DATA_DELAY = 1,
    parameter int LSB_FIRST  = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic [WIDTH-1:0] rx_data,
    output logic [3:0]       rx_slot,
    output logic             rx_valid,
    output logic             tx_underrun,
    output logic             frame_done,
    output logic             busy,
    output logic             sclk,
    output logic             fs,
    output logic             dx,
    input  logic             dr
);

    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
    localparam logic [3:0] SLOT_LAST = 4'(SLOTS - 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [1:0] SYNC_LAST =
        (DATA_DELAY > 0) ? 2'(DATA_DELAY - 1) : 2'd0;
    localparam bit LSBF = (LSB_FIRST != 0);

    typedef enum logic [1:0] {
        IDLE,
        SYNC,
        DATA
    } state_t;

    state_t state, state_n;

    logic [DW-1:0]    div_cnt;
    logic             f_evt, r_evt;
    logic [BW-1:0]    bit_cnt, bit_n;
    logic [3:0]       slot_cnt, slot_n;
    logic [1:0]       sync_cnt, sync_n;
    logic [WIDTH-1:0] tx_sh, tx_sh_n, tx_shifted;
    logic [WIDTH-1:0] hold, hold_n;
    logic             hold_full, hold_full_n;
    logic [WIDTH-1:0] rx_sh, rx_sh_n;
    logic             dx_n, fs_n, busy_n, under_n, done_n;
    logic             start_frame, load_slot, accept;

    // Bit clock: falling-edge cycle launches data, rising-edge cycle samples
    assign f_evt = (div_cnt == DIV_LAST) && sclk;
    assign r_evt = (div_cnt == DIV_LAST) && !sclk;
    assign accept = tx_valid && tx_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_cnt <= '0;
            sclk    <= 1'b0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            sclk    <= ~sclk;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        tx_shifted = LSBF ? (tx_sh >> 1) : (tx_sh << 1);
        rx_sh_n = LSBF ? {dr, rx_sh[WIDTH-1:1]}
                       : {rx_sh[WIDTH-2:0], dr};
    end

    always_comb begin
        state_n     = state;
        bit_n       = bit_cnt;
        slot_n      = slot_cnt;
        sync_n      = sync_cnt;
        tx_sh_n     = tx_sh;
        hold_n      = hold;
        hold_full_n = hold_full;
        dx_n        = dx;
        fs_n        = fs;
        busy_n      = busy;
        under_n     = 1'b0;
        done_n      = 1'b0;
        start_frame = 1'b0;
        load_slot   = 1'b0;

        if (f_evt) begin
            unique case (state)
                IDLE: begin
                    start_frame = en;
                end
                SYNC: begin
                    fs_n = 1'b0;
                    if (sync_cnt == SYNC_LAST) begin
                        state_n   = DATA;
                        bit_n     = '0;
                        slot_n    = '0;
                        load_slot = 1'b1;
                    end else begin
                        sync_n = sync_cnt + 2'd1;
                    end
                end
                DATA: begin
                    fs_n = 1'b0;
                    if (bit_cnt != BIT_LAST) begin
                        bit_n   = bit_cnt + 1'b1;
                        tx_sh_n = tx_shifted;
                        dx_n    = LSBF ? tx_shifted[0]
                                       : tx_shifted[WIDTH-1];
                    end else if (slot_cnt != SLOT_LAST) begin
                        slot_n    = slot_cnt + 4'd1;
                        bit_n     = '0;
                        load_slot = 1'b1;
                    end else begin
                        done_n = 1'b1;
                        if (en) begin
                            start_frame = 1'b1;
                        end else begin
                            state_n = IDLE;
                            busy_n  = 1'b0;
                            dx_n    = 1'b0;
                        end
                    end
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end

        if (start_frame) begin
            fs_n   = 1'b1;
            busy_n = 1'b1;
            slot_n = '0;
            bit_n  = '0;
            sync_n = '0;
            if (DATA_DELAY == 0) begin
                state_n   = DATA;
                load_slot = 1'b1;
            end else begin
                state_n = SYNC;
                dx_n    = 1'b0;
            end
        end

        // Holding state is judged before this cycle's handshake
        if (load_slot) begin
            if (hold_full) begin
                tx_sh_n     = hold;
                dx_n        = LSBF ? hold[0] : hold[WIDTH-1];
                hold_full_n = 1'b0;
            end else begin
                tx_sh_n = '0;
                dx_n    = 1'b0;
                under_n = 1'b1;
            end
        end

        if (accept) begin
            hold_n      = tx_data;
            hold_full_n = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bit_cnt     <= '0;
            slot_cnt    <= '0;
            sync_cnt    <= '0;
            tx_sh       <= '0;
            hold        <= '0;
            hold_full   <= 1'b0;
            tx_ready    <= 1'b0;
            dx          <= 1'b0;
            fs          <= 1'b0;
            busy        <= 1'b0;
            tx_underrun <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            bit_cnt     <= bit_n;
            slot_cnt    <= slot_n;
            sync_cnt    <= sync_n;
            tx_sh       <= tx_sh_n;
            hold        <= hold_n;
            hold_full   <= hold_full_n;
            tx_ready    <= !hold_full_n;
            dx          <= dx_n;
            fs          <= fs_n;
            busy        <= busy_n;
            tx_underrun <= under_n;
            frame_done  <= done_n;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_sh    <= '0;
            rx_data  <= '0;
            rx_slot  <= '0;
            rx_valid <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (r_evt && state == DATA) begin
                rx_sh <= rx_sh_n;
                if (bit_cnt == BIT_LAST) begin
                    rx_data  <= rx_sh_n;
                    rx_slot  <= slot_cnt;
                    rx_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mcbsp_tdm_master.sv
// Bench for mcbsp_tdm_master: two looped-back instances, rx scoreboard,
// frame timing monitors.
module tb_mcbsp_tdm_master;

    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic         en_a, en_b;
    logic [W-1:0] txd_a, txd_b;
    logic         txv_a, txv_b;
    logic         txr_a, txr_b;
    logic [W-1:0] rxd_a, rxd_b;
    logic [3:0]   rxs_a, rxs_b;
    logic         rxv_a, rxv_b;
    logic         und_a, und_b;
    logic         done_a, done_b;
    logic         busy_a, busy_b;
    logic         sclk_a, sclk_b;
    logic         fs_a, fs_b;
    logic         dx_a, dx_b;
    logic         dr_a, dr_b;

    assign dr_a = dx_a;
    assign dr_b = dx_b;

    mcbsp_tdm_master #(
        .WIDTH(W), .SLOTS(2), .CLK_DIV(2),
        .DATA_DELAY(1), .LSB_FIRST(0)
    ) u_a (
        .clk(clk), .rst_n(rst_n), .en(en_a),
        .tx_data(txd_a), .tx_valid(txv_a), .tx_ready(txr_a),
        .rx_data(rxd_a), .rx_slot(rxs_a), .rx_valid(rxv_a),
        .tx_underrun(und_a), .frame_done(done_a), .busy(busy_a),
        .sclk(sclk_a), .fs(fs_a), .dx(dx_a), .dr(dr_a)
    );

    mcbsp_tdm_master #(
        .WIDTH(W), .SLOTS(2), .CLK_DIV(2),
        .DATA_DELAY(0), .LSB_FIRST(1)
    ) u_b (
        .clk(clk), .rst_n(rst_n), .en(en_b),
        .tx_data(txd_b), .tx_valid(txv_b), .tx_ready(txr_b),
        .rx_data(rxd_b), .rx_slot(rxs_b), .rx_valid(rxv_b),
        .tx_underrun(und_b), .frame_done(done_b), .busy(busy_b),
        .sclk(sclk_b), .fs(fs_b), .dx(dx_b), .dr(dr_b)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    logic [11:0] q_a[$];
    logic [11:0] q_b[$];

    int cyc = 0;
    int fs_hi[2], fs_rises[2], t_fs[2], iv_min[2], iv_max[2];
    int dones[2], t_done[2], unders[2], t_under[2], busy_gap[2];
    logic dx_at_fs[2];
    logic fs_q[2];

    task automatic clr(input int i);
        fs_hi[i] = 0; fs_rises[i] = 0; t_fs[i] = 0;
        iv_min[i] = 1 << 30; iv_max[i] = 0;
        dones[i] = 0; t_done[i] = 0; unders[i] = 0;
        t_under[i] = 0; busy_gap[i] = 0; dx_at_fs[i] = 1'b0;
    endtask

    task automatic mon(input int i, input logic f, input logic d,
                       input logic u, input logic b, input logic x);
        int iv;
        if (f) fs_hi[i]++;
        if (f && !fs_q[i]) begin
            if (fs_rises[i] > 0) begin
                iv = cyc - t_fs[i];
                if (iv < iv_min[i]) iv_min[i] = iv;
                if (iv > iv_max[i]) iv_max[i] = iv;
            end
            fs_rises[i]++;
            t_fs[i] = cyc;
            dx_at_fs[i] = x;
        end
        fs_q[i] = f;
        if (d) begin dones[i]++; t_done[i] = cyc; end
        if (u) begin unders[i]++; t_under[i] = cyc; end
        if (!b && dones[i] < fs_rises[i]) busy_gap[i]++;
    endtask

    always @(posedge clk) begin
        logic [11:0] e;
        #1;
        cyc++;
        mon(0, fs_a, done_a, und_a, busy_a, dx_a);
        mon(1, fs_b, done_b, und_b, busy_b, dx_b);
        if (rxv_a) begin
            if (q_a.size() == 0) begin
                chk("rx_a_unexpected", {rxs_a, rxd_a}, 32'hFFFF);
            end else begin
                e = q_a.pop_front();
                chk("rx_a_data", rxd_a, e[7:0]);
                chk("rx_a_slot", rxs_a, e[11:8]);
            end
        end
        if (rxv_b) begin
            if (q_b.size() == 0) begin
                chk("rx_b_unexpected", {rxs_b, rxd_b}, 32'hFFFF);
            end else begin
                e = q_b.pop_front();
                chk("rx_b_data", rxd_b, e[7:0]);
                chk("rx_b_slot", rxs_b, e[11:8]);
            end
        end
    end

    task automatic send(input int i, input logic [W-1:0] w);
        int n;
        n = 0;
        @(negedge clk);
        if (i == 0) begin txd_a = w; txv_a = 1'b1; end
        else begin txd_b = w; txv_b = 1'b1; end
        while (!((i == 0) ? txr_a : txr_b)) begin
            @(negedge clk);
            n++;
            if (n > 400) begin
                chk("send_timeout", 0, 1);
                break;
            end
        end
        @(negedge clk);
        txv_a = 1'b0;
        txv_b = 1'b0;
    endtask

    task automatic wait_rises(input int i, input int n);
        int k;
        k = 0;
        while (fs_rises[i] < n) begin
            @(negedge clk);
            k++;
            if (k > 2000) begin
                chk("fs_timeout", fs_rises[i], n);
                break;
            end
        end
    endtask

    task automatic wait_dones(input int i, input int n);
        int k;
        k = 0;
        while (dones[i] < n) begin
            @(negedge clk);
            k++;
            if (k > 2000) begin
                chk("done_timeout", dones[i], n);
                break;
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [31:0] outs_a();
        return {rxd_a, rxs_a, rxv_a, und_a, done_a, busy_a,
                sclk_a, fs_a, dx_a, txr_a};
    endfunction

    function automatic logic [31:0] outs_b();
        return {rxd_b, rxs_b, rxv_b, und_b, done_b, busy_b,
                sclk_b, fs_b, dx_b, txr_b};
    endfunction

    initial begin
        en_a = 0; en_b = 0;
        txd_a = '0; txd_b = '0;
        txv_a = 0; txv_b = 0;
        fs_q[0] = 0; fs_q[1] = 0;
        clr(0); clr(1);
        idle(3);
        chk("reset_outs_a", outs_a(), 0);
        chk("reset_outs_b", outs_b(), 0);
        rst_n = 1'b1;
        idle(1);
        chk("ready_after_rst", txr_a, 1);

        // one frame, both slots supplied
        clr(0);
        send(0, 8'hA5);
        q_a.push_back({4'd0, 8'hA5});
        en_a = 1;
        send(0, 8'h3C);
        q_a.push_back({4'd1, 8'h3C});
        en_a = 0;
        wait_dones(0, 1);
        idle(20);
        chk("t1_fs_hi", fs_hi[0], 4);
        chk("t1_done_lat", t_done[0] - t_fs[0], 68);
        chk("t1_underruns", unders[0], 0);
        chk("t1_q_empty", q_a.size(), 0);

        // slot 1 underrun
        clr(0);
        send(0, 8'hA5);
        q_a.push_back({4'd0, 8'hA5});
        q_a.push_back({4'd1, 8'h00});
        en_a = 1;
        wait_rises(0, 1);
        en_a = 0;
        wait_dones(0, 1);
        idle(20);
        chk("t2_underruns", unders[0], 1);
        chk("t2_under_time", t_under[0] - t_fs[0], 36);
        chk("t2_q_empty", q_a.size(), 0);

        // no data delay, LSB first
        clr(1);
        send(1, 8'h01);
        q_b.push_back({4'd0, 8'h01});
        q_b.push_back({4'd1, 8'h00});
        en_b = 1;
        wait_rises(1, 1);
        en_b = 0;
        wait_dones(1, 1);
        idle(20);
        chk("t3_dx_at_fs", dx_at_fs[1], 1);
        chk("t3_fs_hi", fs_hi[1], 4);
        chk("t3_done_lat", t_done[1] - t_fs[1], 64);
        chk("t3_underruns", unders[1], 1);
        chk("t3_q_empty", q_b.size(), 0);

        // three back-to-back frames
        clr(1);
        for (int k = 0; k < 6; k++) begin
            logic [7:0] w;
            w = 8'($urandom_range(0, 255));
            q_b.push_back({4'(k % 2), w});
            send(1, w);
            if (k == 0) en_b = 1;
        end
        en_b = 0;
        wait_dones(1, 3);
        idle(200);
        chk("t4_fs_rises", fs_rises[1], 3);
        chk("t4_dones", dones[1], 3);
        chk("t4_iv_min", iv_min[1], 64);
        chk("t4_iv_max", iv_max[1], 64);
        chk("t4_busy_gap", busy_gap[1], 0);
        chk("t4_underruns", unders[1], 0);
        chk("t4_q_empty", q_b.size(), 0);

        // en dropped during slot 0
        clr(0);
        send(0, 8'h96);
        q_a.push_back({4'd0, 8'h96});
        en_a = 1;
        wait_rises(0, 1);
        send(0, 8'h69);
        q_a.push_back({4'd1, 8'h69});
        en_a = 0;
        wait_dones(0, 1);
        idle(1);
        chk("t5_busy_low", busy_a, 0);
        idle(150);
        chk("t5_fs_rises", fs_rises[0], 1);
        chk("t5_dones", dones[0], 1);
        chk("t5_q_empty", q_a.size(), 0);

        // reset mid slot 1
        clr(0);
        send(0, 8'hE1);
        q_a.push_back({4'd0, 8'hE1});
        en_a = 1;
        wait_rises(0, 1);
        send(0, 8'h1E);
        en_a = 0;
        while (cyc - t_fs[0] < 48) @(negedge clk);
        chk("t6_pre_busy", busy_a, 1);
        rst_n = 0;
        idle(1);
        chk("t6_rst_outs", outs_a(), 0);
        rst_n = 1;
        idle(50);
        chk("t6_no_done", dones[0], 0);
        chk("t6_q_empty", q_a.size(), 0);
        clr(0);
        send(0, 8'h5A);
        q_a.push_back({4'd0, 8'h5A});
        en_a = 1;
        wait_rises(0, 1);
        send(0, 8'hC3);
        q_a.push_back({4'd1, 8'hC3});
        en_a = 0;
        wait_dones(0, 1);
        idle(20);
        chk("t6_done_lat", t_done[0] - t_fs[0], 68);
        chk("t6_underruns", unders[0], 0);
        chk("t6_q_end", q_a.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
